hawk_axiwr_arb: RTL and testbench

HAWK_AXIWR_ARB -- requirements
Module: hawk_axiwr_arb

---
 rtl/hacd_pkg.sv | 49 ++++
 rtl/hawk_id_fifo.sv | 54 +++++
 rtl/hawk_axiwr_arb.sv | 179 +++++++++++++++++
 tb/tb_hawk_axiwr_arb.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_pkg.sv
// Shared types and constants for the hawk AXI write path: request/ready/response
// packets, requester id type and the arbiter's FSM encoding.
package hacd_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam int unsigned HAWK_NUM_OUTSTANDING = 8;

  typedef logic req_id_t;
  localparam req_id_t REQ_S0 = 1'b0;
  localparam req_id_t REQ_S1 = 1'b1;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  awvalid;
    logic                  wvalid;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  typedef struct packed {
    logic       bvalid;
    logic [1:0] bresp;
  } axi_wr_resppkt_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE_AW = 2'd1,
    ARB_ISSUE_W  = 2'd2
  } arb_state_e;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/hawk_id_fifo.sv
// Order FIFO of requester ids: remembers which requester owns each write issued
// on the master port so B responses can be routed back in issue order.
module hawk_id_fifo
  import hacd_pkg::*;
#(
  parameter int unsigned DEPTH = HAWK_NUM_OUTSTANDING,
  localparam int unsigned PTR_W = clogb2(DEPTH),
  localparam int unsigned CNT_W = clogb2(DEPTH) + 1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t pop_id,
  output logic    full,
  output logic    empty
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  req_id_t          mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_id  = mem[rd_ptr_reg];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= push_id;
  end

endmodule

// File: rtl/hawk_axiwr_arb.sv
// Two-requester single-beat AXI write arbiter: per-requester holding slots,
// round-robin grant onto one master port, and in-order B response routing.
module hawk_axiwr_arb
  import hacd_pkg::*;
#(
  parameter int unsigned NUM_OUTSTANDING = HAWK_NUM_OUTSTANDING
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  axi_wr_reqpkt_t  s0_wr_reqpkt,
  output axi_wr_rdypkt_t  s0_wr_rdypkt,
  output axi_wr_resppkt_t s0_wr_resppkt,
  input  axi_wr_reqpkt_t  s1_wr_reqpkt,
  output axi_wr_rdypkt_t  s1_wr_rdypkt,
  output axi_wr_resppkt_t s1_wr_resppkt,
  output axi_wr_reqpkt_t  m_wr_reqpkt,
  input  axi_wr_rdypkt_t  m_wr_rdypkt,
  input  axi_wr_resppkt_t m_wr_resppkt,
  output logic            m_bready,
  output logic            bus_error,
  output logic            arb_idle
);

  arb_state_e state_reg, state_next;
  req_id_t    grant_reg, grant_next;
  req_id_t    last_reg, last_next;
  logic       bus_error_reg;

  axi_wr_reqpkt_t  s_req  [2];
  axi_wr_rdypkt_t  s_rdy  [2];
  axi_wr_resppkt_t s_resp [2];

  logic [AXI_ADDR_W-1:0] slot_addr [2];
  logic [AXI_DATA_W-1:0] slot_data [2];
  logic [AXI_STRB_W-1:0] slot_strb [2];
  logic [1:0]            slot_elig;
  logic [1:0]            slot_busy;

  logic    fifo_push;
  logic    fifo_full;
  logic    fifo_empty;
  req_id_t fifo_pop_id;
  logic    b_hs;
  logic    w_hs;

  assign s_req[0]      = s0_wr_reqpkt;
  assign s_req[1]      = s1_wr_reqpkt;
  assign s0_wr_rdypkt  = s_rdy[0];
  assign s1_wr_rdypkt  = s_rdy[1];
  assign s0_wr_resppkt = s_resp[0];
  assign s1_wr_resppkt = s_resp[1];

  assign m_bready  = !fifo_empty;
  assign b_hs      = m_wr_resppkt.bvalid && m_bready;
  assign bus_error = bus_error_reg;
  assign arb_idle  = (state_reg == ARB_IDLE) && fifo_empty && (slot_busy == 2'b00);

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [AXI_ADDR_W-1:0] addr_reg;
    logic [AXI_DATA_W-1:0] data_reg;
    logic [AXI_STRB_W-1:0] strb_reg;
    logic                  aw_reg;
    logic                  w_reg;
    axi_wr_resppkt_t       resp_reg;
    logic                  clr;

    assign clr = w_hs && (grant_reg == req_id_t'(gi));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        addr_reg <= '0;
        data_reg <= '0;
        strb_reg <= '0;
        aw_reg   <= 1'b0;
        w_reg    <= 1'b0;
      end else if (clr) begin
        aw_reg <= 1'b0;
        w_reg  <= 1'b0;
      end else begin
        if (s_req[gi].awvalid && !aw_reg) begin
          aw_reg   <= 1'b1;
          addr_reg <= s_req[gi].addr;
        end
        if (s_req[gi].wvalid && aw_reg && !w_reg) begin
          w_reg    <= 1'b1;
          data_reg <= s_req[gi].data;
          strb_reg <= s_req[gi].strb;
        end
      end
    end

    // B response is a registered one-cycle pulse to the owner of the FIFO head.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        resp_reg <= '0;
      end else if (b_hs && (fifo_pop_id == req_id_t'(gi))) begin
        resp_reg <= '{bvalid: 1'b1, bresp: m_wr_resppkt.bresp};
      end else begin
        resp_reg <= '0;
      end
    end

    assign s_rdy[gi]     = '{awready: !aw_reg, wready: aw_reg && !w_reg};
    assign s_resp[gi]    = resp_reg;
    assign slot_addr[gi] = addr_reg;
    assign slot_data[gi] = data_reg;
    assign slot_strb[gi] = strb_reg;
    assign slot_elig[gi] = aw_reg && w_reg && !fifo_full;
    assign slot_busy[gi] = aw_reg || w_reg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ARB_IDLE;
      grant_reg     <= REQ_S0;
      last_reg      <= REQ_S1;
      bus_error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      if ((b_hs && (m_wr_resppkt.bresp != 2'b00)) || (m_wr_resppkt.bvalid && fifo_empty)) begin
        bus_error_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    last_next   = last_reg;
    m_wr_reqpkt = '0;
    fifo_push   = 1'b0;
    w_hs        = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (slot_elig != 2'b00) begin
          state_next = ARB_ISSUE_AW;
          if (slot_elig == 2'b11) grant_next = ~last_reg;
          else                    grant_next = slot_elig[1] ? REQ_S1 : REQ_S0;
        end
      end
      ARB_ISSUE_AW: begin
        m_wr_reqpkt.awvalid = 1'b1;
        m_wr_reqpkt.addr    = slot_addr[grant_reg];
        if (m_wr_rdypkt.awready) begin
          fifo_push  = 1'b1;
          state_next = ARB_ISSUE_W;
        end
      end
      ARB_ISSUE_W: begin
        m_wr_reqpkt.wvalid = 1'b1;
        m_wr_reqpkt.addr   = slot_addr[grant_reg];
        m_wr_reqpkt.data   = slot_data[grant_reg];
        m_wr_reqpkt.strb   = slot_strb[grant_reg];
        if (m_wr_rdypkt.wready) begin
          w_hs       = 1'b1;
          last_next  = grant_reg;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  hawk_id_fifo #(
    .DEPTH(NUM_OUTSTANDING)
  ) u_order_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (fifo_push),
    .push_id(grant_reg),
    .pop    (b_hs),
    .pop_id (fifo_pop_id),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_hawk_axiwr_arb.sv
// Directed bench for hawk_axiwr_arb: a per-cycle vector table for a single write,
// plus hand sequences for round-robin, AW stall, FIFO full, errors and reset.
module tb_hawk_axiwr_arb;
  import hacd_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  axi_wr_reqpkt_t  sreq  [2];
  axi_wr_rdypkt_t  srdy  [2];
  axi_wr_resppkt_t sresp [2];
  axi_wr_reqpkt_t  mreq;
  axi_wr_rdypkt_t  mrdy;
  axi_wr_resppkt_t mresp;
  logic            m_bready;
  logic            bus_error;
  logic            arb_idle;

  int n_vec = 0;
  int n_bad = 0;

  hawk_axiwr_arb #(.NUM_OUTSTANDING(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .s0_wr_reqpkt (sreq[0]),
    .s0_wr_rdypkt (srdy[0]),
    .s0_wr_resppkt(sresp[0]),
    .s1_wr_reqpkt (sreq[1]),
    .s1_wr_rdypkt (srdy[1]),
    .s1_wr_resppkt(sresp[1]),
    .m_wr_reqpkt  (mreq),
    .m_wr_rdypkt  (mrdy),
    .m_wr_resppkt (mresp),
    .m_bready     (m_bready),
    .bus_error    (bus_error),
    .arb_idle     (arb_idle)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        aw;
    logic        w;
    logic [31:0] addr;
    logic [63:0] data;
    logic        m_bv;
    logic        e_awrdy;
    logic        e_wrdy;
    logic        e_awv;
    logic        e_wv;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    logic        e_bready;
    logic        e_s0bv;
    logic        e_s1bv;
    logic        e_idle;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    for (int r = 0; r < 2; r++) sreq[r] = '0;
    mresp = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_s0_awready"}, 64'(srdy[0].awready), 64'd1);
    chk({tag, "_s0_wready"},  64'(srdy[0].wready),  64'd0);
    chk({tag, "_s1_awready"}, 64'(srdy[1].awready), 64'd1);
    chk({tag, "_s1_wready"},  64'(srdy[1].wready),  64'd0);
    chk({tag, "_m_awvalid"},  64'(mreq.awvalid),    64'd0);
    chk({tag, "_m_wvalid"},   64'(mreq.wvalid),     64'd0);
    chk({tag, "_m_addr"},     64'(mreq.addr),       64'd0);
    chk({tag, "_m_data"},     mreq.data,            64'd0);
    chk({tag, "_m_bready"},   64'(m_bready),        64'd0);
    chk({tag, "_s0_bvalid"},  64'(sresp[0].bvalid), 64'd0);
    chk({tag, "_s1_bvalid"},  64'(sresp[1].bvalid), 64'd0);
    chk({tag, "_bus_error"},  64'(bus_error),       64'd0);
    chk({tag, "_arb_idle"},   64'(arb_idle),        64'd1);
    $display("reset check %s done", tag);
  endtask

  task automatic do_reset(input string tag);
    clr_in();
    mrdy  = '0;
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    chk_reset_state(tag);
  endtask

  // Loads one write into requester r's slot: AW pulse then W pulse.
  task automatic load_slot(input int r, input logic [31:0] addr, input logic [63:0] data);
    sreq[r].awvalid = 1'b1;
    sreq[r].addr    = addr;
    step();
    sreq[r].awvalid = 1'b0;
    sreq[r].wvalid  = 1'b1;
    sreq[r].data    = data;
    sreq[r].strb    = 8'hFF;
    step();
    sreq[r].wvalid  = 1'b0;
  endtask

  task automatic pulse_b(input logic [1:0] bresp);
    mresp.bvalid = 1'b1;
    mresp.bresp  = bresp;
    step();
    mresp = '0;
  endtask

  initial begin
    logic [63:0] d0;
    logic [31:0] q[$];
    int ph[2];
    int ld[2];
    int nb[2];
    int t;

    d0 = 64'hDEAD_BEEF_0123_4567;
    //          aw    w     addr      data  bv    awr   wr    awv   wv    e_addr    e_data bready s0bv s1bv idle
    vt[0] = '{1'b1, 1'b0, 32'h1000, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b1, 32'h0,    d0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000, d0,    1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 32'h0,    64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    64'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    64'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    clr_in();
    mrdy = '0;

    // Single s0 write through a master with ready tied high.
    do_reset("rst0");
    mrdy = '{awready: 1'b1, wready: 1'b1};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d_s0_awready", i), 64'(srdy[0].awready), 64'(vt[i].e_awrdy));
      chk($sformatf("v%0d_s0_wready", i),  64'(srdy[0].wready),  64'(vt[i].e_wrdy));
      chk($sformatf("v%0d_m_awvalid", i),  64'(mreq.awvalid),    64'(vt[i].e_awv));
      chk($sformatf("v%0d_m_wvalid", i),   64'(mreq.wvalid),     64'(vt[i].e_wv));
      chk($sformatf("v%0d_m_addr", i),     64'(mreq.addr),       64'(vt[i].e_addr));
      chk($sformatf("v%0d_m_data", i),     mreq.data,            vt[i].e_data);
      chk($sformatf("v%0d_m_bready", i),   64'(m_bready),        64'(vt[i].e_bready));
      chk($sformatf("v%0d_s0_bvalid", i),  64'(sresp[0].bvalid), 64'(vt[i].e_s0bv));
      chk($sformatf("v%0d_s1_bvalid", i),  64'(sresp[1].bvalid), 64'(vt[i].e_s1bv));
      chk($sformatf("v%0d_bus_error", i),  64'(bus_error),       64'd0);
      chk($sformatf("v%0d_arb_idle", i),   64'(arb_idle),        64'(vt[i].e_idle));
      sreq[0].awvalid = vt[i].aw;
      sreq[0].wvalid  = vt[i].w;
      sreq[0].addr    = vt[i].addr;
      sreq[0].data    = vt[i].data;
      sreq[0].strb    = vt[i].w ? 8'hFF : 8'h00;
      mresp.bvalid    = vt[i].m_bv;
      mresp.bresp     = 2'b00;
      $display("vec %0d applied: aw=%0b w=%0b bvalid=%0b", i, vt[i].aw, vt[i].w, vt[i].m_bv);
      step();
    end
    clr_in();

    // Round-robin: both requesters refill as soon as they are freed.
    do_reset("rst1");
    mrdy = '{awready: 1'b1, wready: 1'b1};
    ph = '{0, 0};
    ld = '{0, 0};
    nb = '{0, 0};
    q.delete();
    for (int cyc = 0; cyc < 300 && q.size() < 8; cyc++) begin
      if (mreq.awvalid) q.push_back(mreq.addr);
      for (int r = 0; r < 2; r++) if (sresp[r].bvalid) nb[r]++;
      for (int r = 0; r < 2; r++) begin
        sreq[r].awvalid = 1'b0;
        sreq[r].wvalid  = 1'b0;
        if (ph[r] == 0 && ld[r] < 4 && srdy[r].awready) begin
          sreq[r].awvalid = 1'b1;
          sreq[r].addr    = 32'h2000 + 32'(r) * 32'h1000 + 32'(ld[r]);
          ph[r] = 1;
        end else if (ph[r] == 1 && srdy[r].wready) begin
          sreq[r].wvalid = 1'b1;
          sreq[r].data   = 64'(sreq[r].addr);
          sreq[r].strb   = 8'hFF;
          ph[r] = 0;
          ld[r]++;
        end
      end
      mresp.bvalid = m_bready;
      mresp.bresp  = 2'b00;
      step();
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int r = 0; r < 2; r++) if (sresp[r].bvalid) nb[r]++;
      for (int r = 0; r < 2; r++) sreq[r] = '0;
      mresp.bvalid = m_bready;
      step();
    end
    clr_in();
    chk("rr_grant_count", 64'(q.size()), 64'd8);
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      chk($sformatf("rr_order_%0d", k), 64'(q[k]), 64'(32'h2000 + 32'(k % 2) * 32'h1000 + 32'(k / 2)));
    end
    chk("rr_s0_bresp_count", 64'(nb[0]), 64'd4);
    chk("rr_s1_bresp_count", 64'(nb[1]), 64'd4);
    $display("round-robin sequence: %0d grants, s0 B=%0d s1 B=%0d", q.size(), nb[0], nb[1]);

    // Master AW stall: payload held, W only after the AW handshake.
    do_reset("rst2");
    load_slot(0, 32'h4000, 64'h4444_0000_4444_0000);
    for (t = 0; t < 10 && !mreq.awvalid; t++) step();
    chk("stall_aw_seen", 64'(mreq.awvalid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_awvalid_%0d", k), 64'(mreq.awvalid), 64'd1);
      chk($sformatf("stall_addr_%0d", k),    64'(mreq.addr),    64'h4000);
      chk($sformatf("stall_wvalid_%0d", k),  64'(mreq.wvalid),  64'd0);
      step();
    end
    mrdy.awready = 1'b1;
    step();
    mrdy.awready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall_w_awvalid_%0d", k), 64'(mreq.awvalid), 64'd0);
      chk($sformatf("stall_w_wvalid_%0d", k),  64'(mreq.wvalid),  64'd1);
      chk($sformatf("stall_w_data_%0d", k),    mreq.data,         64'h4444_0000_4444_0000);
      chk($sformatf("stall_w_addr_%0d", k),    64'(mreq.addr),    64'h4000);
      if (k == 1) mrdy.wready = 1'b1;
      step();
    end
    mrdy.wready = 1'b0;
    chk("stall_done_wvalid", 64'(mreq.wvalid), 64'd0);
    chk("stall_s0_free", 64'(srdy[0].awready), 64'd1);
    pulse_b(2'b00);
    chk("stall_s0_bvalid", 64'(sresp[0].bvalid), 64'd1);
    chk("stall_s1_bvalid", 64'(sresp[1].bvalid), 64'd0);
    $display("aw stall sequence done");

    // FIFO full blocks a third grant; error response on the second B.
    do_reset("rst3");
    mrdy = '{awready: 1'b1, wready: 1'b1};
    sreq[0].awvalid = 1'b1; sreq[0].addr = 32'h5000;
    sreq[1].awvalid = 1'b1; sreq[1].addr = 32'h5100;
    step();
    sreq[0].awvalid = 1'b0; sreq[0].wvalid = 1'b1; sreq[0].data = 64'h50; sreq[0].strb = 8'hFF;
    sreq[1].awvalid = 1'b0; sreq[1].wvalid = 1'b1; sreq[1].data = 64'h51; sreq[1].strb = 8'hFF;
    step();
    clr_in();
    q.delete();
    for (t = 0; t < 30; t++) begin
      if (mreq.awvalid) q.push_back(mreq.addr);
      if (q.size() == 2 && srdy[0].awready && srdy[1].awready && !mreq.wvalid) break;
      step();
    end
    chk("full_grants", 64'(q.size()), 64'd2);
    if (q.size() >= 2) begin
      chk("full_first_grant",  64'(q[0]), 64'h5000);
      chk("full_second_grant", 64'(q[1]), 64'h5100);
    end
    load_slot(0, 32'h5200, 64'h52);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_blocked_%0d", k), 64'(mreq.awvalid), 64'd0);
      chk($sformatf("full_bready_%0d", k),  64'(m_bready),     64'd1);
      step();
    end
    pulse_b(2'b00);
    chk("full_b1_s0_bvalid", 64'(sresp[0].bvalid), 64'd1);
    chk("full_b1_s1_bvalid", 64'(sresp[1].bvalid), 64'd0);
    step();
    chk("full_unblock_awvalid", 64'(mreq.awvalid), 64'd1);
    chk("full_unblock_addr",    64'(mreq.addr),    64'h5200);
    for (t = 0; t < 10 && !mreq.wvalid; t++) step();
    chk("full_third_w", 64'(mreq.wvalid), 64'd1);
    step();
    pulse_b(2'b10);
    chk("err_b2_s1_bvalid", 64'(sresp[1].bvalid), 64'd1);
    chk("err_b2_s1_bresp",  64'(sresp[1].bresp),  64'd2);
    chk("err_b2_s0_bvalid", 64'(sresp[0].bvalid), 64'd0);
    chk("err_b2_bus_error", 64'(bus_error),       64'd1);
    pulse_b(2'b00);
    chk("err_b3_s0_bvalid", 64'(sresp[0].bvalid), 64'd1);
    chk("err_b3_s0_bresp",  64'(sresp[0].bresp),  64'd0);
    chk("err_b3_sticky",    64'(bus_error),       64'd1);
    chk("err_b3_bready",    64'(m_bready),        64'd0);
    chk("err_b3_idle",      64'(arb_idle),        64'd1);
    $display("fifo full and error response sequence done");

    // Spurious B with an empty order FIFO.
    do_reset("rst4");
    pulse_b(2'b00);
    chk("spur_bus_error", 64'(bus_error),       64'd1);
    chk("spur_s0_bvalid", 64'(sresp[0].bvalid), 64'd0);
    chk("spur_s1_bvalid", 64'(sresp[1].bvalid), 64'd0);
    step();
    chk("spur_sticky", 64'(bus_error), 64'd1);
    $display("spurious B sequence done");

    // Reset pulsed while a write is in its W phase.
    do_reset("rst5");
    mrdy = '{awready: 1'b1, wready: 1'b0};
    load_slot(0, 32'h6000, 64'h66);
    for (t = 0; t < 10 && !mreq.wvalid; t++) step();
    chk("midrst_in_w", 64'(mreq.wvalid), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_state("midrst_async");
    step();
    rst_i = 1'b0;
    mrdy = '{awready: 1'b1, wready: 1'b1};
    step();
    chk_reset_state("midrst_after");
    pulse_b(2'b00);
    chk("midrst_b_bus_error", 64'(bus_error),       64'd1);
    chk("midrst_b_s0_bvalid", 64'(sresp[0].bvalid), 64'd0);
    chk("midrst_b_s1_bvalid", 64'(sresp[1].bvalid), 64'd0);
    $display("mid-transfer reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
